// File: rtl/tod_event_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tod_event_sequencer : serialises a 32-bit seconds value as 0/1 events, then
// a latch event on the next PPS, sharing the event slot with one user source.
// Rev 1.0
// ---------------------------------------------------------------------------
module tod_event_sequencer #(
  parameter logic [7:0]  EVT_ZERO    = 8'h70,
  parameter logic [7:0]  EVT_ONE     = 8'h71,
  parameter logic [7:0]  EVT_LATCH   = 8'h7d,
  parameter int unsigned BIT_SPACING = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] seconds_i,
  input  logic        load_req_i,
  output logic        load_ack_o,
  input  logic        pps_strobe_i,
  input  logic        user_valid_i,
  input  logic [7:0]  user_event_i,
  output logic        user_ready_o,
  output logic        user_reject_o,
  output logic [7:0]  event_stream_o,
  output logic        busy_o,
  output logic        armed_o,
  output logic [5:0]  bit_count_o,
  output logic        late_error_o
);

  localparam logic [7:0] C_GAP_RELOAD = 8'(BIT_SPACING - 1);
  localparam logic [5:0] C_NUM_BITS   = 6'd32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  ev_q, ev_d;
  logic        ack_q, ack_d;
  logic        rej_q, rej_d;
  logic        late_q, late_d;
  logic        latch_w;
  logic        bit_due_w;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ev_q    <= '0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ev_q    <= ev_d;
      ack_q   <= ack_d;
      rej_q   <= rej_d;
      late_q  <= late_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    ev_d         = 8'h00;
    ack_d        = 1'b0;
    rej_d        = 1'b0;
    late_d       = 1'b0;
    latch_w      = 1'b0;
    bit_due_w    = (state_q == SHIFT) && (gap_q == 8'd0) && (cnt_q < C_NUM_BITS);
    user_ready_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_req_i) begin
          shift_d = seconds_i;
          cnt_d   = '0;
          gap_d   = '0;
          ack_d   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_due_w) begin
          shift_d = {shift_q[30:0], 1'b0};
          cnt_d   = cnt_q + 6'd1;
          gap_d   = C_GAP_RELOAD;
        end else if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end
        // ARMED is entered one cycle after the final bit issues, so a PPS
        // coincident with (or just after) the 32nd bit still counts as late.
        if (cnt_q == C_NUM_BITS) begin
          state_d = ARMED;
        end
        late_d = pps_strobe_i;
      end
      ARMED: begin
        if (pps_strobe_i) begin
          latch_w = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    user_ready_o = rst_ni && user_valid_i && !latch_w && !bit_due_w;

    if (latch_w) begin
      ev_d = EVT_LATCH;
    end else if (bit_due_w) begin
      ev_d = shift_q[31] ? EVT_ONE : EVT_ZERO;
    end else if (user_ready_o) begin
      // Reserved codes would corrupt receiver bit pointers; swallow them.
      if ((user_event_i == EVT_ZERO) || (user_event_i == EVT_ONE) ||
          (user_event_i == EVT_LATCH)) begin
        rej_d = 1'b1;
      end else begin
        ev_d = user_event_i;
      end
    end
  end

  assign load_ack_o     = ack_q;
  assign user_reject_o  = rej_q;
  assign event_stream_o = ev_q;
  assign busy_o         = (state_q == SHIFT) || (state_q == ARMED);
  assign armed_o        = (state_q == ARMED);
  assign bit_count_o    = cnt_q;
  assign late_error_o   = late_q;

endmodule
`default_nettype wire

// File: tb/tb_tod_event_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tod_event_sequencer : directed bench with an expected-event queue and a
// reference time-of-day receiver.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_tod_event_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] seconds = '0;
  logic        load_req = 1'b0;
  logic        pps = 1'b0;
  logic        uv = 1'b0;
  logic [7:0]  ue = '0;
  logic        load_ack, user_ready, user_reject, busy, armed, late_error;
  logic [7:0]  event_stream;
  logic [5:0]  bit_count;

  int          n_checks = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];

  logic [31:0] rx_sh = '0;
  logic [63:0] rx_out = '0;

  tod_event_sequencer #(
    .EVT_ZERO   (8'h70),
    .EVT_ONE    (8'h71),
    .EVT_LATCH  (8'h7d),
    .BIT_SPACING(4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .seconds_i     (seconds),
    .load_req_i    (load_req),
    .load_ack_o    (load_ack),
    .pps_strobe_i  (pps),
    .user_valid_i  (uv),
    .user_event_i  (ue),
    .user_ready_o  (user_ready),
    .user_reject_o (user_reject),
    .event_stream_o(event_stream),
    .busy_o        (busy),
    .armed_o       (armed),
    .bit_count_o   (bit_count),
    .late_error_o  (late_error)
  );

  always #5 clk = ~clk;

  // Downstream receiver: shifts in bit events, publishes {seconds, 0} on latch.
  always @(posedge clk) begin
    if (event_stream == 8'h70 || event_stream == 8'h71)
      rx_sh <= {rx_sh[30:0], event_stream[0]};
    else if (event_stream == 8'h7d)
      rx_out <= {rx_sh, 32'h0};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One slot: optionally check UserReady, queue the expected event, clock,
  // then compare the registered event against the queue head.
  task automatic slot(input logic [7:0] ev, input int rdy);
    #1;
    if (rdy >= 0) chk("user_ready", {63'd0, user_ready}, 64'(rdy));
    exp_q.push_back(ev);
    @(posedge clk);
    #1;
    chk("event", {56'd0, event_stream}, {56'd0, exp_q.pop_front()});
  endtask

  task automatic xfer(input logic [31:0] v, input logic u, input logic [7:0] uc,
                      input int late_k, input int reload_k, input int abort_k,
                      input logic pps_on_load);
    logic [7:0] g;
    int r;
    g = u ? uc : 8'h00;
    r = u ? 1 : 0;
    seconds = v; load_req = 1'b1; uv = u; ue = uc; pps = pps_on_load;
    slot(g, r);
    load_req = 1'b0; pps = 1'b0;
    chk("load_ack", {63'd0, load_ack}, 64'd1);
    chk("busy_after_load", {63'd0, busy}, 64'd1);
    chk("armed_after_load", {63'd0, armed}, 64'd0);
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (k == abort_k && j == 0) begin
          rst_n = 1'b0; uv = 1'b1; ue = 8'h2a;
          slot(8'h00, 0);
          chk("rst_user_ready", {63'd0, user_ready}, 64'd0);
          chk("rst_load_ack", {63'd0, load_ack}, 64'd0);
          chk("rst_user_reject", {63'd0, user_reject}, 64'd0);
          chk("rst_late", {63'd0, late_error}, 64'd0);
          chk("rst_busy", {63'd0, busy}, 64'd0);
          chk("rst_armed", {63'd0, armed}, 64'd0);
          chk("rst_bit_count", {58'd0, bit_count}, 64'd0);
          rst_n = 1'b1; uv = 1'b0;
          return;
        end
        if (j == 0) chk("bit_count", {58'd0, bit_count}, 64'(k));
        if (k == late_k && j == 0) pps = 1'b1;
        if (k == reload_k && j == 1) begin
          load_req = 1'b1; seconds = ~v;
        end
        if (j == 0) slot(v[31-k] ? 8'h71 : 8'h70, 0);
        else        slot(g, r);
        if (pps) begin
          chk("late_error", {63'd0, late_error}, 64'd1);
          pps = 1'b0;
        end
        if (load_req) begin
          chk("reload_ack", {63'd0, load_ack}, 64'd0);
          load_req = 1'b0;
        end
      end
    end
    chk("armed", {63'd0, armed}, 64'd1);
    chk("busy_armed", {63'd0, busy}, 64'd1);
    chk("bit_count_full", {58'd0, bit_count}, 64'd32);
  endtask

  task automatic latch(input logic [7:0] g, input int r);
    slot(g, r);
    slot(g, r);
    chk("still_armed", {63'd0, armed}, 64'd1);
    pps = 1'b1;
    slot(8'h7d, 0);
    pps = 1'b0;
    chk("busy_after_latch", {63'd0, busy}, 64'd0);
    chk("armed_after_latch", {63'd0, armed}, 64'd0);
    chk("count_after_latch", {58'd0, bit_count}, 64'd0);
  endtask

  initial begin
    logic [7:0] codes [4];
    codes[0] = 8'h70; codes[1] = 8'h71; codes[2] = 8'h7d; codes[3] = 8'h55;

    rst_n = 1'b0; uv = 1'b1; ue = 8'h2a;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_event", {56'd0, event_stream}, 64'd0);
    chk("reset_ready", {63'd0, user_ready}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_armed", {63'd0, armed}, 64'd0);
    chk("reset_count", {58'd0, bit_count}, 64'd0);
    chk("reset_ack", {63'd0, load_ack}, 64'd0);
    rst_n = 1'b1; uv = 1'b0;
    slot(8'h00, 0);

    xfer(32'h8000_0001, 1'b0, 8'h00, -1, -1, -1, 1'b0);
    latch(8'h00, 0);
    slot(8'h00, 0);
    chk("rx_out_a", rx_out, 64'h8000_0001_0000_0000);

    xfer(32'hA5C3_0F96, 1'b1, 8'h2a, -1, -1, -1, 1'b0);
    latch(8'h2a, 1);
    slot(8'h2a, 1);
    uv = 1'b0;
    chk("rx_out_b", rx_out, 64'hA5C3_0F96_0000_0000);

    xfer(32'h1234_5678, 1'b0, 8'h00, 10, -1, -1, 1'b0);
    latch(8'h00, 0);
    slot(8'h00, 0);
    chk("rx_out_late", rx_out, 64'h1234_5678_0000_0000);

    for (int i = 0; i < 4; i++) begin
      uv = 1'b1; ue = codes[i];
      slot((i == 3) ? 8'h55 : 8'h00, 1);
      chk("user_reject", {63'd0, user_reject}, (i == 3) ? 64'd0 : 64'd1);
    end
    uv = 1'b0;
    slot(8'h00, 0);
    chk("reject_clear", {63'd0, user_reject}, 64'd0);

    xfer(32'hCAFE_F00D, 1'b0, 8'h00, -1, 5, -1, 1'b1);
    latch(8'h00, 0);
    slot(8'h00, 0);
    chk("rx_out_reload", rx_out, 64'hCAFE_F00D_0000_0000);

    xfer(32'hFFFF_0000, 1'b0, 8'h00, -1, -1, 17, 1'b0);
    slot(8'h00, 0);
    chk("abort_no_latch", rx_out, 64'hCAFE_F00D_0000_0000);
    xfer(32'h0F0F_0F0F, 1'b0, 8'h00, -1, -1, -1, 1'b0);
    latch(8'h00, 0);
    slot(8'h00, 0);
    chk("rx_out_after_abort", rx_out, 64'h0F0F_0F0F_0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
